// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared opcodes, state encodings and DDRAM geometry for the HD44780 responder
package lcd_pkg;

  localparam int DDRAM_DEPTH = 128;
  localparam int AW          = 7;
  localparam logic [7:0] SPACE = 8'h20;

  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPLAY = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  typedef enum logic [1:0] {S_INIT8, S_HI, S_LO, S_CLEAR} state_t;

  // Instruction class is decided by the most significant set bit.
  function automatic logic [7:0] top_bit(input logic [7:0] b);
    top_bit = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) top_bit = 8'b1 << i;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// rtl/lcd_ddram.sv - 128x8 display RAM: core port A (write + registered read), renderer port B
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  output logic [7:0]    a_rdata,
  input  logic [AW-1:0] b_addr,
  output logic [7:0]    b_rdata
);

  logic [7:0] mem [DDRAM_DEPTH];

  always_ff @(posedge CLK) begin
    if (a_we) mem[a_addr] <= a_wdata;
    a_rdata <= mem[a_addr];
  end

  // Registered read samples the array before a same-cycle write lands, so collisions return old data.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) b_rdata <= '0;
    else      b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// rtl/lcd_hd44780_responder.sv - HD44780 4-bit bus responder with DDRAM for display emulation
// Optional: define LCD_RESP_DATA_READ_EN to return DDRAM contents on rs=1 reads.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int                         clk_mhz_width = 8,
  parameter logic [clk_mhz_width-1:0]   clk_mhz       = 240,
  parameter int                         busy_short_us = 37,
  parameter int                         busy_long_us  = 1520
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rs,
  input  logic       rw,
  input  logic       e,
  inout  wire  [3:0] LCD_DATA,
  input  logic [6:0] disp_addr,
  output logic [7:0] disp_char,
  output logic       disp_on,
  output logic       busy
);

  localparam int CW = $clog2(busy_long_us * int'(clk_mhz) + 1);
  localparam logic [CW-1:0] SHORT_C = CW'(busy_short_us * int'(clk_mhz));
  localparam logic [CW-1:0] LONG_C  = CW'(busy_long_us * int'(clk_mhz));
`ifdef LCD_RESP_DATA_READ_EN
  localparam logic RD_EN = 1'b1;
`else
  localparam logic RD_EN = 1'b0;
`endif

  logic [1:0] rs_q, rw_q;
  logic [2:0] e_q;
  logic [3:0] db_q0, db_q1;
  logic       rs_s, rw_s, e_s, fall;
  logic [3:0] db_s;

  state_t        state, state_n;
  logic [AW-1:0] ac, ac_n, clr, clr_n, step;
  logic          id, id_n, disp_on_n;
  logic [3:0]    hi, hi_n, dout;
  logic [CW-1:0] cnt, cnt_n;
  logic          we, lcd_oe;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata, ram_q, byte_w, op;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rs_q <= '0; rw_q <= '0; e_q <= '0; db_q0 <= '0; db_q1 <= '0;
    end else begin
      rs_q  <= {rs_q[0], rs};
      rw_q  <= {rw_q[0], rw};
      e_q   <= {e_q[1:0], e};
      db_q0 <= LCD_DATA;
      db_q1 <= db_q0;
    end
  end

  assign rs_s   = rs_q[1];
  assign rw_s   = rw_q[1];
  assign e_s    = e_q[1];
  assign db_s   = db_q1;
  assign fall   = e_q[2] & ~e_q[1];
  assign busy   = (cnt != '0);
  assign byte_w = {hi, db_s};
  assign op     = top_bit(byte_w);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_INIT8; ac <= '0; id <= 1'b1; disp_on <= 1'b0;
      hi <= '0; cnt <= '0; clr <= '0;
    end else begin
      state <= state_n; ac <= ac_n; id <= id_n; disp_on <= disp_on_n;
      hi <= hi_n; cnt <= cnt_n; clr <= clr_n;
    end
  end

  always_comb begin
    state_n = state; ac_n = ac; id_n = id; disp_on_n = disp_on;
    hi_n = hi; clr_n = clr;
    cnt_n = busy ? cnt - 1'b1 : cnt;
    we = 1'b0; ram_addr = ac; ram_wdata = byte_w;
    step = id ? AW'(1) : '1;
    case (state)
      S_INIT8: if (fall && !rw_s && db_s == 4'h2) begin
        state_n = S_HI;
        cnt_n   = SHORT_C;
      end
      S_HI: if (fall) begin
        hi_n    = db_s;
        state_n = S_LO;
      end
      S_LO: if (fall) begin
        state_n = S_HI;
        if (rw_s) begin
          if (rs_s && RD_EN) ac_n = ac + step;
        end else if (!busy) begin
          // A byte completed while busy is dropped; the nibble phase still advanced.
          cnt_n = SHORT_C;
          if (rs_s) begin
            we   = 1'b1;
            ac_n = ac + step;
          end else if (op == OP_DDRAM) ac_n = byte_w[6:0];
          else if (op == OP_FUNC) begin
            if (byte_w[4]) state_n = S_INIT8;
          end else if (op == OP_SHIFT) begin
            if (!byte_w[3]) ac_n = byte_w[2] ? ac + AW'(1) : ac - AW'(1);
          end else if (op == OP_DISPLAY) disp_on_n = byte_w[2];
          else if (op == OP_ENTRY) id_n = byte_w[1];
          else if (op == OP_HOME) begin
            ac_n  = '0;
            cnt_n = LONG_C;
          end else if (op == OP_CLEAR) begin
            ac_n = '0; id_n = 1'b1; clr_n = '0;
            state_n = S_CLEAR; cnt_n = LONG_C;
          end
        end
      end
      S_CLEAR: begin
        we = 1'b1; ram_addr = clr; ram_wdata = SPACE;
        clr_n = clr + AW'(1);
        if (clr == AW'(DDRAM_DEPTH - 1)) state_n = S_HI;
      end
      default: state_n = S_INIT8;
    endcase
  end

  always_comb begin
    if (state == S_LO) dout = rs_s ? (ram_q[3:0] & {4{RD_EN}}) : ac[3:0];
    else               dout = rs_s ? (ram_q[7:4] & {4{RD_EN}}) : {busy, ac[6:4]};
  end

  assign lcd_oe   = rw_s & e_s;
  assign LCD_DATA = lcd_oe ? dout : 4'bz;

  lcd_ddram u_ddram (
    .CLK     (CLK),
    .RST     (RST),
    .a_we    (we),
    .a_addr  (ram_addr),
    .a_wdata (ram_wdata),
    .a_rdata (ram_q),
    .b_addr  (disp_addr),
    .b_rdata (disp_char)
  );

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb/tb_lcd_hd44780_responder.sv - randomized bus-level bench against a behavioural LCD model
module tb_lcd_hd44780_responder;
  import lcd_pkg::*;

  localparam int MHZ   = 2;
  localparam int SHORT = 37 * MHZ;
  localparam int LONG  = 1520 * MHZ;
`ifdef LCD_RESP_DATA_READ_EN
  localparam bit RD = 1'b1;
`else
  localparam bit RD = 1'b0;
`endif

  logic       CLK = 1'b0, RST = 1'b0, rs = 1'b0, rw = 1'b0, e = 1'b0;
  logic [6:0] disp_addr = '0;
  logic [7:0] disp_char;
  logic       disp_on, busy;
  wire  [3:0] LCD_DATA;
  logic [3:0] tb_db = '0;
  logic       tb_drv = 1'b0;
  assign LCD_DATA = tb_drv ? tb_db : 4'bz;

  lcd_hd44780_responder #(.clk_mhz_width(8), .clk_mhz(8'(MHZ)), .busy_short_us(37), .busy_long_us(1520)) dut (
    .CLK(CLK), .RST(RST), .rs(rs), .rw(rw), .e(e), .LCD_DATA(LCD_DATA),
    .disp_addr(disp_addr), .disp_char(disp_char), .disp_on(disp_on), .busy(busy)
  );

  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: display RAM, address counter, entry direction, display bit.
  logic [7:0] m_mem [128];
  int m_ac = 0;
  bit m_id = 1'b1, m_on = 1'b0;

  function automatic void m_exec(input bit r, input int b);
    if (r) begin
      m_mem[m_ac] = 8'(b);
      m_ac = (m_ac + (m_id ? 1 : 127)) % 128;
    end else if (b >= 128) m_ac = b - 128;
    else if (b >= 32) m_ac = m_ac;
    else if (b >= 16) begin
      if ((b & 8) == 0) m_ac = (m_ac + (((b & 4) != 0) ? 1 : 127)) % 128;
    end else if (b >= 8) m_on = ((b & 4) != 0);
    else if (b >= 4) m_id = ((b & 2) != 0);
    else if (b >= 2) m_ac = 0;
    else if (b == 1) begin
      m_ac = 0; m_id = 1'b1;
      for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
    end
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic put_nib(input logic r, input logic [3:0] n);
    rs = r; rw = 1'b0; tb_db = n; tb_drv = 1'b1;
    wait_clk(2); e = 1'b1; wait_clk(6); e = 1'b0; wait_clk(6);
  endtask

  task automatic get_nib(input logic r, output logic [3:0] n);
    tb_drv = 1'b0; rs = r; rw = 1'b1;
    wait_clk(2); e = 1'b1; wait_clk(6); n = LCD_DATA; e = 1'b0; wait_clk(6); rw = 1'b0;
  endtask

  task automatic put_byte(input logic r, input logic [7:0] b);
    put_nib(r, b[7:4]);
    put_nib(r, b[3:0]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 6000) begin wait_clk(1); n++; end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic send(input logic r, input logic [7:0] b);
    wait_idle();
    put_byte(r, b);
    m_exec(r, int'(b));
  endtask

  task automatic check_ac(input string tag);
    logic [3:0] h, l;
    wait_idle();
    get_nib(1'b0, h);
    get_nib(1'b0, l);
    check(tag, 32'({h, l}), 32'(m_ac));
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 128; a++) begin
      disp_addr = 7'(a);
      wait_clk(1);
      check($sformatf("%s[%0d]", tag, a), 32'(disp_char), 32'(m_mem[a]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [3:0] h, l;
  logic [7:0] exp8;
  int t0, k;

  initial begin
    wait_clk(3);
    check("rst_disp_on", 32'(disp_on), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_disp_char", 32'(disp_char), 32'd0);
    check("rst_oe", 32'(dut.lcd_oe), 32'd0);
    check("rst_state", 32'(dut.state), 32'(S_INIT8));
    RST = 1'b1;
    wait_clk(2);

    put_nib(1'b0, 4'h3); put_nib(1'b0, 4'h3); put_nib(1'b0, 4'h3); put_nib(1'b0, 4'h2);
    check("init_state", 32'(dut.state), 32'(S_HI));
    send(1'b0, 8'h28);
    send(1'b0, 8'h0C);
    check("disp_on_init", 32'(disp_on), 32'(m_on));

    send(1'b0, 8'h80);
    send(1'b1, 8'h41);
    send(1'b1, 8'h42);
    get_nib(1'b0, h);
    get_nib(1'b0, l);
    check("bf_hi", 32'(h), 32'h8);
    check("bf_lo", 32'(l), 32'h2);
    check("busy_after_write", 32'(busy), 32'd1);
    wait_idle();
    check("busy_released", 32'(busy), 32'd0);
    disp_addr = 7'd1;
    wait_clk(1);
    check("disp_char_1", 32'(disp_char), 32'h42);
    disp_addr = 7'd0;
    wait_clk(1);
    check("disp_char_0", 32'(disp_char), 32'h41);
    check_ac("ac_after_ab");

    wait_idle();
    put_byte(1'b0, 8'h01);
    t0 = cyc;
    m_exec(1'b0, 1);
    put_byte(1'b1, 8'h77);
    while (busy && (cyc - t0) < 6000) wait_clk(1);
    k = cyc - t0 + 6;
    check("clear_busy_len", 32'(k >= LONG && k <= LONG + 8), 32'd1);
    sweep("clear");
    check_ac("ac_after_clear");

    send(1'b0, 8'hFF);
    check_ac("ac_ff");
    send(1'b1, 8'h55);
    check_ac("ac_wrap_up");
    disp_addr = 7'd127;
    wait_clk(1);
    check("ddram_127", 32'(disp_char), 32'h55);
    send(1'b0, 8'h04);
    send(1'b0, 8'h10);
    check_ac("ac_wrap_down");
    send(1'b0, 8'h02);
    check_ac("ac_home");

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 6);
      case (k)
        0, 1: send(1'b1, 8'($urandom_range(0, 255)));
        2: send(1'b0, 8'h80 | 8'($urandom_range(0, 127)));
        3: send(1'b0, 8'h04 | 8'($urandom_range(0, 3)));
        4: send(1'b0, 8'h10 | 8'($urandom_range(0, 15)));
        5: begin
          send(1'b0, 8'h08 | 8'($urandom_range(0, 7)));
          check("disp_on_rand", 32'(disp_on), 32'(m_on));
        end
        default: begin
          wait_idle();
          get_nib(1'b1, h);
          get_nib(1'b1, l);
          exp8 = RD ? m_mem[m_ac] : 8'h00;
          check("data_read", 32'({h, l}), 32'(exp8));
          if (RD) m_ac = (m_ac + (m_id ? 1 : 127)) % 128;
        end
      endcase
      check_ac("ac_rand");
    end
    sweep("final");

    wait_idle();
    put_byte(1'b1, 8'h31);
    put_nib(1'b1, 4'h3);
    check("pre_rst_busy", 32'(busy), 32'd1);
    tb_drv = 1'b0; rs = 1'b0; rw = 1'b1; e = 1'b1;
    wait_clk(4);
    check("pre_rst_oe", 32'(dut.lcd_oe), 32'd1);
    RST = 1'b0;
    wait_clk(1);
    check("midrst_state", 32'(dut.state), 32'(S_INIT8));
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_oe", 32'(dut.lcd_oe), 32'd0);
    e = 1'b0; rw = 1'b0;
    RST = 1'b1;
    wait_clk(4);
    check("post_rst_state", 32'(dut.state), 32'(S_INIT8));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
